// File: rtl/fmrv32im_axil_timer.sv
// fmrv32im_axil_timer: AXI4-Lite machine timer, prescaled 64-bit mtime,
// 64-bit mtimecmp and a registered level interrupt.
module fmrv32im_axil_timer #(
  parameter logic [15:0] PRESCALE_INIT = 16'd0,
  parameter logic [63:0] CMP_INIT = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        RST_N,
  input  logic        CLK,
  input  logic [15:0] S_AXI_AWADDR,
  input  logic [3:0]  S_AXI_AWCACHE,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  output logic [1:0]  S_AXI_BRESP,
  input  logic [15:0] S_AXI_ARADDR,
  input  logic [3:0]  S_AXI_ARCACHE,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic        TIMER_IRQ
);

  localparam logic [2:0] A_MLO  = 3'd0;
  localparam logic [2:0] A_MHI  = 3'd1;
  localparam logic [2:0] A_CLO  = 3'd2;
  localparam logic [2:0] A_CHI  = 3'd3;
  localparam logic [2:0] A_CTRL = 3'd4;
  localparam logic [2:0] A_STAT = 3'd5;
  localparam logic [2:0] A_PRE  = 3'd6;

  logic [63:0] mtime, mtime_d;
  logic [63:0] mtimecmp, cmp_d;
  logic        en, en_d;
  logic        ie, ie_d;
  logic [15:0] prescale, pre_d;
  logic [15:0] pcnt, pcnt_d;
  logic [31:0] shadow;
  logic        aw_held, w_held;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        bvalid;
  logic [1:0]  bresp, bresp_d;
  logic        rvalid;
  logic [31:0] rdata, rd_d;
  logic [1:0]  rresp, rr_d;
  logic        irq;
  logic        tick, commit, reached;
  logic        aw_hs, w_hs, ar_hs;
  logic [2:0]  ar_sel;

  logic unused;
  assign unused = ^{S_AXI_AWCACHE, S_AXI_AWPROT,
                    S_AXI_ARCACHE, S_AXI_ARPROT,
                    S_AXI_AWADDR[15:5], S_AXI_AWADDR[1:0],
                    S_AXI_ARADDR[15:5], S_AXI_ARADDR[1:0]};

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  assign S_AXI_AWREADY = RST_N & ~aw_held & ~bvalid;
  assign S_AXI_WREADY  = RST_N & ~w_held & ~bvalid;
  assign S_AXI_ARREADY = RST_N & ~rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;
  assign TIMER_IRQ     = irq;

  assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
  assign ar_sel  = S_AXI_ARADDR[4:2];
  assign commit  = aw_held & w_held;
  assign tick    = en & (pcnt == prescale);
  assign reached = mtime >= mtimecmp;

  // A committed mtime write replaces this cycle's increment.
  always_comb begin
    mtime_d = tick ? mtime + 64'd1 : mtime;
    cmp_d   = mtimecmp;
    en_d    = en;
    ie_d    = ie;
    pre_d   = prescale;
    pcnt_d  = pcnt;
    bresp_d = 2'b00;
    if (en) pcnt_d = tick ? 16'd0 : pcnt + 16'd1;
    if (commit) begin
      unique case (wr_addr)
        A_MLO: mtime_d = {mtime[63:32],
                          merge(mtime[31:0], wr_data, wr_strb)};
        A_MHI: mtime_d = {merge(mtime[63:32], wr_data, wr_strb),
                          mtime[31:0]};
        A_CLO: cmp_d[31:0] =
                 merge(mtimecmp[31:0], wr_data, wr_strb);
        A_CHI: cmp_d[63:32] =
                 merge(mtimecmp[63:32], wr_data, wr_strb);
        A_CTRL: begin
          if (wr_strb[0]) begin
            en_d = wr_data[0];
            ie_d = wr_data[1];
          end
        end
        A_PRE: begin
          if (wr_strb[0]) pre_d[7:0] = wr_data[7:0];
          if (wr_strb[1]) pre_d[15:8] = wr_data[15:8];
          pcnt_d = 16'd0;
        end
        default: bresp_d = 2'b10;
      endcase
    end
  end

  always_comb begin
    rd_d = 32'd0;
    rr_d = 2'b00;
    unique case (ar_sel)
      A_MLO:  rd_d = mtime[31:0];
      A_MHI:  rd_d = shadow;
      A_CLO:  rd_d = mtimecmp[31:0];
      A_CHI:  rd_d = mtimecmp[63:32];
      A_CTRL: rd_d = {30'd0, ie, en};
      A_STAT: rd_d = {31'd0, reached};
      A_PRE:  rd_d = {16'd0, prescale};
      default: rr_d = 2'b10;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mtime    <= 64'd0;
      mtimecmp <= CMP_INIT;
      en       <= 1'b0;
      ie       <= 1'b0;
      prescale <= PRESCALE_INIT;
      pcnt     <= 16'd0;
      shadow   <= 32'd0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      wr_addr  <= 3'd0;
      wr_data  <= 32'd0;
      wr_strb  <= 4'd0;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
      rvalid   <= 1'b0;
      rdata    <= 32'd0;
      rresp    <= 2'b00;
      irq      <= 1'b0;
    end else begin
      mtime    <= mtime_d;
      mtimecmp <= cmp_d;
      en       <= en_d;
      ie       <= ie_d;
      prescale <= pre_d;
      pcnt     <= pcnt_d;
      irq      <= ie & reached;
      if (aw_hs) begin
        aw_held <= 1'b1;
        wr_addr <= S_AXI_AWADDR[4:2];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wr_data <= S_AXI_WDATA;
        wr_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= bresp_d;
      end else if (bvalid & S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
      // LO read snapshots HI so a LO/HI pair is atomic.
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_d;
        rresp  <= rr_d;
        if (ar_sel == A_MLO) shadow <= mtime[63:32];
      end else if (rvalid & S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fmrv32im_axil_timer.sv
// tb_fmrv32im_axil_timer: directed and random bus traffic checked
// every cycle against a transaction-level timer model.
module tb_fmrv32im_axil_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] awaddr = '0;
  logic [3:0]  awcache = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [1:0]  bresp;
  logic [15:0] araddr = '0;
  logic [3:0]  arcache = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  fmrv32im_axil_timer dut (
    .RST_N(rst_n), .CLK(clk),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWCACHE(awcache),
    .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_BRESP(bresp),
    .S_AXI_ARADDR(araddr), .S_AXI_ARCACHE(arcache),
    .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .TIMER_IRQ(irq)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++)
      b[i] = s[i] ? d[i*8 +: 8] : o[i*8 +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Model: mtime ticks on every (PRESCALE+1)-th enabled cycle,
  // counted from the last PRESCALE write or reset.
  logic [63:0] m_time, m_cmp, o_time, o_cmp;
  bit          m_en, m_ie, o_en, o_ie;
  logic [15:0] m_pre, o_pre;
  longint unsigned m_phase;
  logic [31:0] m_shadow, v;
  logic [2:0]  aw_q [$];
  logic [35:0] w_q [$];
  logic [2:0]  qa;
  logic [35:0] qw;
  bit          m_bv, m_rv, o_bv, o_rv, aw_free, w_free;
  logic [1:0]  m_br, m_rr;
  logic [31:0] m_rd;
  bit          m_irq;
  bit          started = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_time = '0; m_cmp = '1; m_en = 0; m_ie = 0;
      m_pre = '0; m_phase = 0; m_shadow = '0;
      aw_q.delete(); w_q.delete();
      m_bv = 0; m_br = '0; m_rv = 0; m_rd = '0; m_rr = '0;
      m_irq = 0; started = 1'b1;
    end else if (started) begin
      o_time = m_time; o_cmp = m_cmp; o_en = m_en; o_ie = m_ie;
      o_pre = m_pre; o_bv = m_bv; o_rv = m_rv;
      aw_free = (aw_q.size() == 0) && !o_bv;
      w_free = (w_q.size() == 0) && !o_bv;
      m_irq = o_ie && (o_time >= o_cmp);
      if (o_en) begin
        if (((m_phase + 1) % (64'(o_pre) + 1)) == 0)
          m_time = o_time + 64'd1;
        m_phase++;
      end
      if (o_bv && bready) m_bv = 0;
      if (aw_q.size() != 0 && w_q.size() != 0) begin
        qa = aw_q.pop_front();
        qw = w_q.pop_front();
        m_bv = 1; m_br = 2'b00;
        case (qa)
          3'd0: m_time = {o_time[63:32],
                          lanes(o_time[31:0], qw[31:0], qw[35:32])};
          3'd1: m_time = {lanes(o_time[63:32], qw[31:0], qw[35:32]),
                          o_time[31:0]};
          3'd2: m_cmp[31:0] = lanes(o_cmp[31:0], qw[31:0], qw[35:32]);
          3'd3: m_cmp[63:32] = lanes(o_cmp[63:32], qw[31:0], qw[35:32]);
          3'd4: begin
            v = lanes({30'd0, o_ie, o_en}, qw[31:0], qw[35:32]);
            m_en = v[0]; m_ie = v[1];
          end
          3'd6: begin
            v = lanes({16'd0, o_pre}, qw[31:0], qw[35:32]);
            m_pre = v[15:0]; m_phase = 0;
          end
          default: m_br = 2'b10;
        endcase
      end
      if (awvalid && aw_free) aw_q.push_back(awaddr[4:2]);
      if (wvalid && w_free) w_q.push_back({wstrb, wdata});
      if (o_rv && rready) m_rv = 0;
      if (arvalid && !o_rv) begin
        m_rv = 1; m_rr = 2'b00;
        case (araddr[4:2])
          3'd0: begin m_rd = o_time[31:0]; m_shadow = o_time[63:32]; end
          3'd1: m_rd = m_shadow;
          3'd2: m_rd = o_cmp[31:0];
          3'd3: m_rd = o_cmp[63:32];
          3'd4: m_rd = {30'd0, o_ie, o_en};
          3'd5: m_rd = {31'd0, o_time >= o_cmp};
          3'd6: m_rd = {16'd0, o_pre};
          default: begin m_rd = '0; m_rr = 2'b10; end
        endcase
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (started) begin
      chk("awready", awready, rst_n && aw_q.size() == 0 && !m_bv);
      chk("wready", wready, rst_n && w_q.size() == 0 && !m_bv);
      chk("arready", arready, rst_n && !m_rv);
      chk("bvalid", bvalid, m_bv);
      chk("bresp", bresp, m_br);
      chk("rvalid", rvalid, m_rv);
      chk("rdata", rdata, m_rd);
      chk("rresp", rresp, m_rr);
      chk("irq", irq, m_irq);
    end
  end

  task automatic wr(input logic [15:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [1:0] resp);
    int n;
    bit ag, wg;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      ag = awvalid && awready;
      wg = wvalid && wready;
      @(negedge clk);
      if (ag) awvalid = 0;
      if (wg) wvalid = 0;
      n++;
    end
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk("b_wait", bvalid, 1);
    resp = bresp;
    @(negedge clk);
    bready = 0; awvalid = 0; wvalid = 0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d,
                    output logic [1:0] r);
    int n;
    bit g;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    n = 0;
    while (arvalid && n < 50) begin
      g = arready;
      @(negedge clk);
      if (g) arvalid = 0;
      n++;
    end
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    chk("r_wait", rvalid, 1);
    d = rdata; r = rresp;
    @(negedge clk);
    rready = 0; arvalid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, t;
    logic [1:0]  r;
    int n, hold;
    bit g;
    repeat (3) @(negedge clk);
    rst_n = 1;

    chk("irq_after_reset", irq, 0);
    rd(16'h00, d, r); chk("rst_mlo", d, 0); chk("rst_resp", r, 0);
    rd(16'h04, d, r); chk("rst_mhi", d, 0);
    rd(16'h08, d, r); chk("rst_clo", d, 32'hFFFF_FFFF);
    rd(16'h0C, d, r); chk("rst_chi", d, 32'hFFFF_FFFF);
    rd(16'h10, d, r); chk("rst_ctrl", d, 0);
    rd(16'h14, d, r); chk("rst_stat", d, 0);
    rd(16'h18, d, r); chk("rst_pre", d, 0);
    rd(16'h1C, d, r); chk("unmap_data", d, 0);
    chk("unmap_rresp", r, 2'b10);

    wr(16'h18, 32'd3, 4'hF, r);
    wr(16'h10, 32'd1, 4'hF, r);
    repeat (40) @(negedge clk);
    rd(16'h00, d, r); chk("prescale_mlo", d, 32'd10);

    wr(16'h10, 32'd0, 4'hF, r);
    wr(16'h18, 32'd0, 4'hF, r);
    wr(16'h00, 32'hFFFF_FFFE, 4'hF, r);
    wr(16'h04, 32'h0, 4'hF, r);
    wr(16'h08, 32'h0, 4'hF, r);
    wr(16'h0C, 32'h1, 4'hF, r);
    wr(16'h10, 32'd3, 4'hF, r);
    @(negedge clk); chk("irq_not_yet", irq, 0);
    @(negedge clk); chk("irq_rise", irq, 1);
    rd(16'h00, d, r);
    rd(16'h04, d, r); chk("irq_mhi", d, 1);
    wr(16'h0C, 32'h2, 4'hF, r);
    chk("irq_fall", irq, 0);

    wr(16'h10, 32'd0, 4'hF, r);
    @(negedge clk);
    wdata = 32'h0000_AB00; wstrb = 4'b0010; wvalid = 1; bready = 0;
    repeat (3) begin
      g = wvalid && wready;
      @(negedge clk);
      if (g) wvalid = 0;
    end
    awaddr = 16'h18; awvalid = 1;
    n = 0;
    while (awvalid && n < 50) begin
      g = awready;
      @(negedge clk);
      if (g) awvalid = 0;
      n++;
    end
    @(negedge clk);
    hold = 0;
    repeat (5) begin
      if (bvalid) hold++;
      @(negedge clk);
    end
    chk("bvalid_held", hold, 5);
    chk("split_bresp", bresp, 0);
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk("bvalid_clear", bvalid, 0);
    rd(16'h18, d, r); chk("strb_pre", d, 32'h0000_AB00);

    wr(16'h04, 32'h1, 4'hF, r);
    wr(16'h00, 32'hFFFF_FFFF, 4'hF, r);
    rd(16'h00, d, r); chk("wrap_mlo", d, 32'hFFFF_FFFF);
    wr(16'h18, 32'd0, 4'hF, r);
    wr(16'h10, 32'd1, 4'hF, r);
    repeat (5) @(negedge clk);
    rd(16'h04, d, r); chk("shadow_hi", d, 1);
    rd(16'h00, d, r);
    rd(16'h04, d, r); chk("new_hi", d, 2);

    wr(16'h00, 32'h1234_5678, 4'hF, r);
    rd(16'h00, d, r); chk("mlo_win", d, 32'h1234_567A);
    rd(16'h04, d, r); chk("mhi_kept", d, 2);

    wr(16'h14, 32'hFFFF_FFFF, 4'hF, r); chk("stat_wr", r, 2'b10);
    wr(16'h1C, 32'hFFFF_FFFF, 4'hF, r); chk("unmap_wr", r, 2'b10);
    wr(16'h10, 32'd0, 4'hF, r); chk("ctrl_wr", r, 2'b00);

    @(negedge clk);
    awaddr = 16'h18; awvalid = 1;
    n = 0;
    while (awvalid && n < 50) begin
      g = awready;
      @(negedge clk);
      if (g) awvalid = 0;
      n++;
    end
    rst_n = 0;
    wdata = 32'h5555; wstrb = 4'hF; wvalid = 1;
    repeat (2) @(negedge clk);
    wvalid = 0; rst_n = 1;
    @(negedge clk);
    chk("rst_bvalid", bvalid, 0);
    rd(16'h18, d, r); chk("rst_abort_pre", d, 0);
    rd(16'h00, d, r); chk("rst_abort_mlo", d, 0);
    wr(16'h18, 32'd7, 4'hF, r); chk("post_rst_resp", r, 0);
    rd(16'h18, d, r); chk("post_rst_pre", d, 7);

    for (int i = 0; i < 150; i++) begin
      t = $urandom;
      case ($urandom_range(0, 3))
        0: wr({t[10:0], 3'($urandom_range(0, 7)), 2'b00},
              $urandom, 4'($urandom), r);
        1: rd({t[10:0], 3'($urandom_range(0, 7)), 2'b00}, d, r);
        2: begin
          rd(16'h00, d, r);
          repeat ($urandom_range(0, 4)) @(negedge clk);
          rd(16'h04, d, r);
        end
        default: repeat ($urandom_range(0, 3)) @(negedge clk);
      endcase
      if (i % 50 == 0)
        wr(16'h18, 32'($urandom_range(0, 3)), 4'hF, r);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
